// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the EEPROM controller and the on-chip EEPROM target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } I2cState;

  localparam logic [6:0] I2C_EEPROM_ADDR = 7'h50;
  localparam logic       I2C_RW_READ     = 1'b1;
  localparam logic       I2C_RW_WRITE    = 1'b0;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP as one-clk pulses.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so leaving reset never fakes an edge on an idle bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 256x8 EEPROM: byte/sequential writes, current/random/sequential reads.
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = I2C_EEPROM_ADDR,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  I2cState        r_state, w_state_nxt;
  logic [2:0]     r_cnt, w_cnt_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [AW-1:0]  r_ptr, w_ptr_nxt;
  logic           r_phase, w_phase_nxt;
  logic           r_rw, w_rw_nxt;
  logic           r_oe, w_oe_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_stb, w_stb_nxt;
  logic [AW-1:0]  r_waddr, w_waddr_nxt;
  logic [7:0]     r_wdata, w_wdata_nxt;
  logic           w_mem_we;
  logic [7:0]     r_mem [MEM_DEPTH];

  logic [7:0]     w_byte;
  logic [AW-1:0]  w_ptr_inc;
  logic [7:0]     w_rd_byte;
  logic [7:0]     w_rd_next;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_ptr_inc = r_ptr + AW'(1);
  assign w_rd_byte = r_mem[r_ptr];
  assign w_rd_next = r_mem[w_ptr_inc];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ptr   <= '0;
      r_phase <= 1'b0;
      r_rw    <= I2C_RW_WRITE;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_stb   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_ptr   <= w_ptr_nxt;
      r_phase <= w_phase_nxt;
      r_rw    <= w_rw_nxt;
      r_oe    <= w_oe_nxt;
      r_busy  <= w_busy_nxt;
      r_stb   <= w_stb_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  // r_phase: in ACK states "ACK already driven"; in RD_DATA "all 8 bits driven, release next".
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_ptr_nxt   = r_ptr;
    w_phase_nxt = r_phase;
    w_rw_nxt    = r_rw;
    w_oe_nxt    = r_oe;
    w_busy_nxt  = r_busy;
    w_stb_nxt   = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_mem_we    = 1'b0;
    if (w_start) begin
      w_state_nxt = ST_DEV_ADDR;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
      w_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_DEV_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            if (w_byte[7:1] == DEV_ADDR) begin
              w_state_nxt = ST_DEV_ACK;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = w_byte[0];
              w_phase_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_oe_nxt    = 1'b1;
            w_phase_nxt = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            if (r_state == ST_DEV_ACK && r_rw == I2C_RW_READ) begin
              // The fall ending the ACK also launches read bit 7.
              w_oe_nxt    = ~w_rd_byte[7];
              w_shift_nxt = {w_rd_byte[6:0], 1'b0};
              w_cnt_nxt   = 3'd1;
              w_state_nxt = ST_RD_DATA;
            end else if (r_state == ST_DEV_ACK) begin
              w_state_nxt = ST_WORD_ADDR;
            end else begin
              w_state_nxt = ST_WR_DATA;
            end
          end
        end
        ST_WORD_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_ptr_nxt   = w_byte[AW-1:0];
            w_phase_nxt = 1'b0;
            w_state_nxt = ST_WORD_ACK;
          end
        end
        ST_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_mem_we    = 1'b1;
            w_stb_nxt   = 1'b1;
            w_waddr_nxt = r_ptr;
            w_wdata_nxt = w_byte;
            w_ptr_nxt   = w_ptr_inc;
            w_phase_nxt = 1'b0;
            w_state_nxt = ST_WR_ACK;
          end
        end
        ST_RD_DATA: if (w_scl_fall) begin
          if (r_phase) begin
            w_oe_nxt    = 1'b0;
            w_phase_nxt = 1'b0;
            w_state_nxt = ST_RD_ACK;
          end else begin
            w_oe_nxt    = ~r_shift[7];
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_phase_nxt = 1'b1;
          end
        end
        ST_RD_ACK: if (w_scl_rise) begin
          w_ptr_nxt = w_ptr_inc;
          if (!w_sda) begin
            w_shift_nxt = w_rd_next;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RD_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_stb;
  assign wr_addr   = r_waddr;
  assign wr_data   = r_wdata;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench: bit-banged I2C master drives the EEPROM target and checks ACKs, data and strobes.
`timescale 1ns/1ps
module tb_i2c_eeprom_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;

  assign sda_line = sda_m & ~sda_oe;
  always #10 clk = ~clk;

  i2c_eeprom_target #(.DEV_ADDR(7'h50), .MEM_DEPTH(256), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] stb_q[$];
  int          oe_cnt = 0;
  int          bad_chg = 0;
  logic        prev_oe = 1'b0;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) stb_q.push_back({wr_addr, wr_data});
    if (sda_oe === 1'b1) oe_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n && sda_oe !== prev_oe && scl !== 1'b0) bad_chg++;
    prev_oe <= sda_oe;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl   = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl   = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    b = sda_line; wq();
    scl = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, b;
    logic [7:0] d;
    int         base, oe_base;

    repeat (5) @(negedge clk);
    check_val("rst_sda_oe", 32'(sda_oe), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_wr_strobe", 32'(wr_strobe), 0);
    check_val("rst_wr_addr", 32'(wr_addr), 0);
    check_val("rst_wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    wq();

    // Seed 06 = 77 for the current-address read later.
    i2c_start(); wbyte(8'hA0, a); wbyte(8'h06, a); wbyte(8'h77, a); i2c_stop();

    // 1: byte write
    base = stb_q.size();
    i2c_start();
    wbyte(8'hA0, a); check_val("t1_ack_dev", 32'(a), 0);
    check_val("t1_busy", 32'(busy), 1);
    wbyte(8'h05, a); check_val("t1_ack_word", 32'(a), 0);
    wbyte(8'h3C, a); check_val("t1_ack_data", 32'(a), 0);
    i2c_stop();
    check_val("t1_busy_after_p", 32'(busy), 0);
    check_val("t1_strobes", 32'(stb_q.size() - base), 1);
    check_val("t1_strobe0", 32'(stb_q[base]), 'h053C);

    // 2: random read, then current-address read at 06
    i2c_start(); wbyte(8'hA0, a); wbyte(8'h05, a);
    i2c_start(); wbyte(8'hA1, a); check_val("t2_ack_rd", 32'(a), 0);
    rbyte(d, 1'b1);
    i2c_stop();
    check_val("t2_data", 32'(d), 'h3C);
    check_val("t2_busy_after_p", 32'(busy), 0);
    i2c_start(); wbyte(8'hA1, a); rbyte(d, 1'b1); i2c_stop();
    check_val("t2_ptr06_data", 32'(d), 'h77);

    // 3: sequential write across wrap
    base = stb_q.size();
    i2c_start(); wbyte(8'hA0, a); wbyte(8'hFE, a);
    wbyte(8'h11, a); wbyte(8'h22, a); wbyte(8'h33, a);
    check_val("t3_ack_last", 32'(a), 0);
    i2c_stop();
    check_val("t3_strobes", 32'(stb_q.size() - base), 3);
    check_val("t3_strobe0", 32'(stb_q[base]), 'hFE11);
    check_val("t3_strobe1", 32'(stb_q[base+1]), 'hFF22);
    check_val("t3_strobe2", 32'(stb_q[base+2]), 'h0033);

    // 4: set ptr=FE, then sequential read with wrap
    i2c_start(); wbyte(8'hA0, a); wbyte(8'hFE, a); i2c_stop();
    i2c_start(); wbyte(8'hA1, a);
    rbyte(d, 1'b0); check_val("t4_rd0", 32'(d), 'h11);
    rbyte(d, 1'b0); check_val("t4_rd1", 32'(d), 'h22);
    rbyte(d, 1'b1); check_val("t4_rd2", 32'(d), 'h33);
    i2c_stop();

    // 5: wrong device address
    base = stb_q.size();
    oe_base = oe_cnt;
    i2c_start();
    wbyte(8'hA4, a); check_val("t5_nack_dev", 32'(a), 1);
    check_val("t5_busy", 32'(busy), 0);
    wbyte(8'h05, a); wbyte(8'h99, a);
    i2c_stop();
    check_val("t5_oe_never", 32'(oe_cnt - oe_base), 0);
    check_val("t5_strobes", 32'(stb_q.size() - base), 0);

    // 6a: STOP after 4 data bits
    i2c_start(); wbyte(8'hA0, a); wbyte(8'h10, a); wbyte(8'hA5, a); i2c_stop();
    base = stb_q.size();
    i2c_start(); wbyte(8'hA0, a); wbyte(8'h10, a);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    check_val("t6a_strobes", 32'(stb_q.size() - base), 0);
    i2c_start(); wbyte(8'hA1, a); rbyte(d, 1'b1); i2c_stop();
    check_val("t6a_ptr_kept", 32'(d), 'hA5);

    // 6b: reset during RD_DATA (mem[05]=3C: bits 7,6 are 0 so SDA is held low)
    i2c_start(); wbyte(8'hA0, a); wbyte(8'h05, a);
    i2c_start(); wbyte(8'hA1, a);
    rbit(b); check_val("t6b_bit7", 32'(b), 0);
    check_val("t6b_oe_before", 32'(sda_oe), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("t6b_oe_reset", 32'(sda_oe), 0);
    check_val("t6b_busy_reset", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wq();
    i2c_stop();
    i2c_start(); wbyte(8'hA1, a); rbyte(d, 1'b1); i2c_stop();
    check_val("t6b_ptr_reset_data", 32'(d), 'h33);

    check_val("sda_chg_while_scl_high", 32'(bad_chg), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
